// File: rtl/sipo_deser.sv
// sipo_deser: serial-in/parallel-out deserializer feeding a PIPO register.
// Serial bits arrive under a valid/ready handshake and are packed into a
// WIDTH-bit word. The finished word sits in a separate output register with
// its own valid/ready handshake, so the shifter can collect the next word's
// bits while the current word waits to be taken.
//
//   state | meaning
//   IDLE  | no partial word held, bit_cnt == 0
//   SHIFT | collecting bits of a partial word
//   STALL | WIDTH-1 bits held, output full, final bit refused until drain
module sipo_deser #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CW       = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             si_i,
  input  logic             si_valid_i,
  output logic             si_ready_o,
  output logic [WIDTH-1:0] po_o,
  output logic             po_valid_o,
  input  logic             po_ready_i,
  output logic [CW-1:0]    bit_cnt_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    STALL = 2'd2
  } state_t;

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q;
  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;
  logic [WIDTH-1:0] po_q;
  logic             po_valid_q;
  logic [CW-1:0]    bit_cnt_q;

  logic last_bit;
  logic out_blocked;
  logic acc;
  logic drain;
  logic complete;

  assign last_bit    = (bit_cnt_q == LAST);
  // The final bit may only enter when the output register can take the word.
  assign out_blocked = last_bit & po_valid_q & ~po_ready_i;
  assign si_ready_o  = (state_q != STALL) & ~out_blocked;
  assign acc         = si_valid_i & si_ready_o;
  assign drain       = po_valid_q & po_ready_i;
  assign complete    = acc & last_bit;

  // Shift register contents after accepting the current serial bit.
  always_comb begin
    sr_d = sr_q;
    if (MSB_FIRST) sr_d = {sr_q[WIDTH-2:0], si_i};
    else           sr_d = {si_i, sr_q[WIDTH-1:1]};
  end

  // Shifter, output word register and sequencing FSM.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      po_q       <= '0;
      po_valid_q <= 1'b0;
      bit_cnt_q  <= '0;
    end else if (clr_i) begin
      // po keeps its last word; only the valid flag and partial word go.
      state_q    <= IDLE;
      sr_q       <= '0;
      po_valid_q <= 1'b0;
      bit_cnt_q  <= '0;
    end else begin
      if (acc) begin
        sr_q      <= sr_d;
        bit_cnt_q <= complete ? '0 : bit_cnt_q + 1'b1;
      end

      // A load in the same cycle as a drain keeps po_valid high.
      if (complete) begin
        po_q       <= sr_d;
        po_valid_q <= 1'b1;
      end else if (drain) begin
        po_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (acc) state_q <= SHIFT;
        end
        SHIFT: begin
          if (complete)                     state_q <= IDLE;
          else if (out_blocked & si_valid_i) state_q <= STALL;
        end
        STALL: begin
          if (drain) state_q <= SHIFT;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign po_o       = po_q;
  assign po_valid_o = po_valid_q;
  assign bit_cnt_o  = bit_cnt_q;
  assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_sipo_deser.sv
// Directed bench for sipo_deser: an MSB-first and an LSB-first instance
// share the same stimulus; expected words are queued as bits are accepted
// and compared whenever a word is drained.
module tb_sipo_deser;

  logic clk = 1'b0;
  logic rst_n, clr, si, si_valid, po_ready;

  logic       si_ready_m, po_valid_m, busy_m;
  logic [3:0] po_m;
  logic [1:0] bit_cnt_m;
  logic       si_ready_l, po_valid_l, busy_l;
  logic [3:0] po_l;
  logic [1:0] bit_cnt_l;

  always #5 clk = ~clk;

  sipo_deser #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .si_i(si), .si_valid_i(si_valid),
    .si_ready_o(si_ready_m), .po_o(po_m), .po_valid_o(po_valid_m),
    .po_ready_i(po_ready), .bit_cnt_o(bit_cnt_m), .busy_o(busy_m));

  sipo_deser #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .si_i(si), .si_valid_i(si_valid),
    .si_ready_o(si_ready_l), .po_o(po_l), .po_valid_o(po_valid_l),
    .po_ready_i(po_ready), .bit_cnt_o(bit_cnt_l), .busy_o(busy_l));

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int pv_cycles = 0;
  int drain_at[$];
  logic [3:0] q_m[$];
  logic [3:0] q_l[$];
  int bidx = 0;
  logic [3:0] wm = '0;
  logic [3:0] wl = '0;
  logic last_acc = 1'b0;
  logic last_ready = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: sample at negedge (scoreboard on drain), then update
  // the bit-placement model on the rising edge.
  task automatic tick();
    logic [3:0] e;
    @(negedge clk);
    last_ready = si_ready_m;
    last_acc   = si_valid && si_ready_m && !clr && rst_n;
    if (po_valid_m) pv_cycles++;
    if (rst_n && !clr && po_valid_m && po_ready) begin
      drain_at.push_back(cyc);
      chk("sb_nonempty", q_m.size() != 0, 1);
      if (q_m.size() != 0) begin
        e = q_m.pop_front();
        chk("sb_word_msb", po_m, e);
      end
      if (q_l.size() != 0) begin
        e = q_l.pop_front();
        chk("sb_word_lsb", po_l, e);
      end
    end
    @(posedge clk);
    cyc++;
    if (clr) begin
      bidx = 0; wm = '0; wl = '0;
    end else if (last_acc) begin
      wm[3-bidx] = si;
      wl[bidx]   = si;
      bidx++;
      if (bidx == 4) begin
        q_m.push_back(wm);
        q_l.push_back(wl);
        bidx = 0;
      end
    end
    #1;
  endtask

  task automatic send_bit(input logic b);
    si = b;
    si_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (last_acc) return;
    end
    n_vec++;
    n_err++;
    $error("FAIL send_timeout observed=not_accepted expected=accepted");
  endtask

  initial begin
    logic [3:0] w;
    rst_n = 1'b0; clr = 1'b0; si = 1'b0; si_valid = 1'b0; po_ready = 1'b0;
    #2;
    chk("rst_po", po_m, 4'h0);
    chk("rst_po_valid", po_valid_m, 0);
    chk("rst_bit_cnt", bit_cnt_m, 0);
    chk("rst_si_ready", si_ready_m, 1);
    chk("rst_busy", busy_m, 0);
    chk("rst_busy_lsb", {busy_l, bit_cnt_l, si_ready_l, po_valid_l}, 5'b00010);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic MSB-first word, output consumed immediately.
    po_ready = 1'b1;
    send_bit(1'b1);
    chk("t2_busy_mid", busy_m, 1);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    chk("t2_po", po_m, 4'b1010);
    chk("t2_po_lsb", po_l, 4'b0101);
    chk("t2_po_valid", po_valid_m, 1);
    chk("t2_bit_cnt", bit_cnt_m, 0);
    chk("t2_busy", busy_m, 0);
    si_valid = 1'b0;
    tick();
    chk("t2_pulse_end", po_valid_m, 0);
    chk("t2_po_hold", po_m, 4'b1010);

    // Async reset mid-word with a full output register.
    po_ready = 1'b0;
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b1);
    si_valid = 1'b0;
    chk("t1_pre_bit_cnt", bit_cnt_m, 2);
    chk("t1_pre_po_valid", po_valid_m, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t1_po", po_m, 4'h0);
    chk("t1_po_valid", po_valid_m, 0);
    chk("t1_bit_cnt", bit_cnt_m, 0);
    chk("t1_si_ready", si_ready_m, 1);
    chk("t1_busy", busy_m, 0);
    q_m.delete(); q_l.delete(); bidx = 0; wm = '0; wl = '0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Backpressure into STALL, then drain and finish the word.
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    chk("t3_bit_cnt", bit_cnt_m, 3);
    si = 1'b0; si_valid = 1'b1;
    tick();
    chk("t3_refused", last_ready, 0);
    chk("t3_stall_ready", si_ready_m, 0);
    chk("t3_stall_busy", busy_m, 1);
    chk("t3_stall_cnt", bit_cnt_m, 3);
    tick();
    chk("t3_still_refused", last_ready, 0);
    po_ready = 1'b1;
    tick();
    chk("t3_drain_cycle_refused", last_ready, 0);
    chk("t3_drained", po_valid_m, 0);
    po_ready = 1'b0;
    tick();
    chk("t3_final_taken", last_ready, 1);
    chk("t3_po", po_m, 4'b1000);
    chk("t3_po_lsb", po_l, 4'b0001);
    chk("t3_po_valid", po_valid_m, 1);
    si_valid = 1'b0;

    // Drain and load on the same edge.
    po_ready = 1'b1;
    tick();
    po_ready = 1'b0;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    chk("t4_pre_po", po_m, 4'b1010);
    chk("t4_pre_valid", po_valid_m, 1);
    po_ready = 1'b1;
    send_bit(1'b0);
    chk("t4_po", po_m, 4'b1100);
    chk("t4_valid_kept", po_valid_m, 1);
    si_valid = 1'b0;
    tick();
    chk("t4_drained", po_valid_m, 0);

    // Synchronous clear after two bits.
    send_bit(1'b1); send_bit(1'b1);
    chk("t5_pre_cnt", bit_cnt_m, 2);
    si = 1'b1; si_valid = 1'b1; clr = 1'b1;
    tick();
    clr = 1'b0; si_valid = 1'b0;
    chk("t5_cnt", bit_cnt_m, 0);
    chk("t5_busy", busy_m, 0);
    chk("t5_po_valid", po_valid_m, 0);
    chk("t5_po_kept", po_m, 4'b1100);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    chk("t5_po", po_m, 4'b0110);
    chk("t5_po_lsb", po_l, 4'b0110);
    si_valid = 1'b0;
    tick();

    // Continuous stream of 8 words.
    drain_at.delete();
    pv_cycles = 0;
    po_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      w = 4'($urandom_range(0, 15));
      for (int b = 3; b >= 0; b--) send_bit(w[b]);
    end
    si_valid = 1'b0;
    tick(); tick();
    chk("t6_words", drain_at.size(), 8);
    chk("t6_pv_cycles", pv_cycles, 8);
    for (int k = 1; k < drain_at.size(); k++)
      chk("t6_spacing", drain_at[k] - drain_at[k-1], 4);
    chk("t6_sb_msb_empty", q_m.size(), 0);
    chk("t6_sb_lsb_empty", q_l.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
